// File: rtl/rom_ctrl_pkg.sv
// rom_ctrl_pkg: shared types for the rom_ctrl digest capture path.
package rom_ctrl_pkg;
  // Only four codes fit at distance 3 in 5 bits; Error sits at distance >= 2 from all of them.
  typedef enum logic [4:0] {
    StCapture = 5'b10101,
    StWaitK   = 5'b10010,
    StStart   = 5'b01100,
    StDone    = 5'b01011,
    StError   = 5'b11111
  } state_e;
  function automatic int vbits(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/prim_count.sv
// prim_count: saturating up-counter with an inverted shadow copy for fault detection.
module prim_count #(
  parameter int Width = 3,
  parameter logic [Width-1:0] MaxVal = '1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             incr_en_i,
  output logic [Width-1:0] cnt_o,
  output logic             err_o
);
  logic [Width-1:0] cnt_d, cnt_q, cnt_n_d, cnt_n_q;
  always_comb begin
    cnt_d   = (incr_en_i && cnt_q != MaxVal) ? cnt_q + Width'(1) : cnt_q;
    cnt_n_d = ~cnt_d;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      cnt_n_q <= '1;
    end else begin
      cnt_q   <= cnt_d;
      cnt_n_q <= cnt_n_d;
    end
  end
  assign cnt_o = cnt_q;
  assign err_o = cnt_q != ~cnt_n_q;
endmodule

// File: rtl/rom_ctrl_digest_capture.sv
// rom_ctrl_digest_capture: captures the expected digest from the ROM sweep and the KMAC digest, then starts the compare.
// Define ROM_CTRL_CAPTURE_MASK_EN to hide both digests until capture_done_o.
module rom_ctrl_digest_capture
  import rom_ctrl_pkg::*;
#(
  parameter  int RomDepth = 8192,
  parameter  int NumWords = 8,
  localparam int RomAW    = $clog2(RomDepth)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  rom_vld_i,
  input  logic [RomAW-1:0]      rom_addr_i,
  input  logic [31:0]           rom_data_i,
  input  logic                  kmac_vld_i,
  input  logic [NumWords*32-1:0] kmac_digest_i,
  output logic [NumWords*32-1:0] exp_digest_o,
  output logic [NumWords*32-1:0] digest_o,
  output logic                  start_o,
  output logic                  capture_done_o,
  output logic                  alert_o
);
  localparam int CntW = vbits(NumWords);
  localparam logic [RomAW-1:0] TopBase = RomAW'(RomDepth - NumWords);
  localparam logic [CntW-1:0] LastCnt = CntW'(NumWords - 1);

  state_e state_d, state_q;
  logic [NumWords*32-1:0] exp_d, exp_q, dig_d, dig_q;
  logic seen_d, seen_q, alert_d, alert_q;
  logic [CntW-1:0] cnt;
  logic cnt_err, top, in_cap, hit, last, kmac_new;

  assign top      = rom_vld_i && rom_addr_i >= TopBase;
  assign in_cap   = state_q == StCapture;
  assign hit      = top && in_cap && rom_addr_i == TopBase + RomAW'(cnt);
  assign last     = hit && cnt == LastCnt;
  assign kmac_new = kmac_vld_i && !seen_q && (in_cap || state_q == StWaitK);

  prim_count #(
    .Width (CntW),
    .MaxVal(LastCnt)
  ) u_cnt (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .incr_en_i(hit),
    .cnt_o    (cnt),
    .err_o    (cnt_err)
  );

  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    dig_d   = kmac_new ? kmac_digest_i : dig_q;
    seen_d  = seen_q | kmac_new;
    alert_d = alert_q | cnt_err | (top && !hit) | (kmac_vld_i && seen_q);
    if (hit) exp_d[32*cnt +: 32] = rom_data_i;
    case (state_q)
      StCapture: if (last) state_d = (seen_q || kmac_vld_i) ? StStart : StWaitK;
      StWaitK:   if (kmac_vld_i) state_d = StStart;
      StStart:   state_d = StDone;
      StDone:    state_d = StDone;
      StError:   alert_d = 1'b1;
      default: begin
        state_d = StError;
        alert_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StCapture;
      exp_q   <= '0;
      dig_q   <= '0;
      seen_q  <= 1'b0;
      alert_q <= 1'b0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      dig_q   <= dig_d;
      seen_q  <= seen_d;
      alert_q <= alert_d;
    end
  end

  assign start_o        = state_q == StStart;
  assign capture_done_o = state_q == StDone;
  assign alert_o        = alert_q;
`ifdef ROM_CTRL_CAPTURE_MASK_EN
  assign exp_digest_o = capture_done_o ? exp_q : '0;
  assign digest_o     = capture_done_o ? dig_q : '0;
`else
  assign exp_digest_o = exp_q;
  assign digest_o     = dig_q;
`endif
endmodule

// File: tb/tb_rom_ctrl_digest_capture.sv
// tb_rom_ctrl_digest_capture: randomized directed bench with a word-array reference model.
module tb_rom_ctrl_digest_capture;
  localparam int RomDepth = 8192;
  localparam int NumWords = 8;
  localparam int RomAW = 13;
  localparam int TopBase = RomDepth - NumWords;
  localparam int W = NumWords * 32;

  logic clk_i = 1'b0, rst_ni = 1'b0, rom_vld_i = 1'b0, kmac_vld_i = 1'b0;
  logic [RomAW-1:0] rom_addr_i = '0;
  logic [31:0] rom_data_i = '0;
  logic [W-1:0] kmac_digest_i = '0, exp_digest_o, digest_o;
  logic start_o, capture_done_o, alert_o;

  int checks = 0, failures = 0;
  logic [31:0] m_exp[NumWords];
  logic [W-1:0] m_dig;
  int nexp, cycle = 0, exp_start, act_start, pulses;
  bit kseen, m_alert;

  always #5 clk_i = ~clk_i;

  rom_ctrl_digest_capture dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .rom_vld_i(rom_vld_i), .rom_addr_i(rom_addr_i),
    .rom_data_i(rom_data_i), .kmac_vld_i(kmac_vld_i), .kmac_digest_i(kmac_digest_i),
    .exp_digest_o(exp_digest_o), .digest_o(digest_o), .start_o(start_o),
    .capture_done_o(capture_done_o), .alert_o(alert_o)
  );

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic model_clear();
    foreach (m_exp[i]) m_exp[i] = '0;
    m_dig = '0; nexp = 0; kseen = 0; m_alert = 0;
    exp_start = -1; act_start = -1; pulses = 0;
  endtask

  function automatic logic [W-1:0] packed_exp();
    logic [W-1:0] r;
    for (int i = 0; i < NumWords; i++) r[i*32 +: 32] = m_exp[i];
    return r;
  endfunction

  task automatic do_reset(input string tag);
    @(negedge clk_i);
    rst_ni = 1'b0; rom_vld_i = 1'b0; kmac_vld_i = 1'b0;
    model_clear();
    #1;
    chk({tag, "/rst_exp"}, exp_digest_o, '0);
    chk({tag, "/rst_dig"}, digest_o, '0);
    chk({tag, "/rst_start"}, W'(start_o), '0);
    chk({tag, "/rst_done"}, W'(capture_done_o), '0);
    chk({tag, "/rst_alert"}, W'(alert_o), '0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic cyc(input bit vld, input int addr, input bit kv);
    @(negedge clk_i);
    rom_vld_i = vld; rom_addr_i = RomAW'(addr); rom_data_i = $urandom; kmac_vld_i = kv;
    for (int i = 0; i < NumWords; i++) kmac_digest_i[i*32 +: 32] = $urandom;
    if (vld && addr >= TopBase) begin
      if (nexp < NumWords && addr == TopBase + nexp) begin
        m_exp[nexp] = rom_data_i;
        nexp++;
      end else m_alert = 1;
    end
    if (kv) begin
      if (kseen) m_alert = 1;
      else begin
        m_dig = kmac_digest_i;
        kseen = 1;
      end
    end
    if (nexp == NumWords && kseen && exp_start < 0) exp_start = cycle;
    @(posedge clk_i);
    #1;
    if (start_o) begin
      pulses++;
      act_start = cycle;
    end
    cycle++;
  endtask

  task automatic sweep(input int lo, input int hi, input int kaddr);
    for (int a = lo; a <= hi; a++) begin
      if ($urandom_range(0, 15) == 0) cyc(0, 0, 0);
      cyc(1, a, a == kaddr);
    end
  endtask

  task automatic check_all(input string tag);
    bit done;
    done = exp_start >= 0 && cycle - 1 > exp_start;
`ifdef ROM_CTRL_CAPTURE_MASK_EN
    chk({tag, "/exp_digest"}, exp_digest_o, done ? packed_exp() : '0);
    chk({tag, "/digest"}, digest_o, done ? m_dig : '0);
`else
    chk({tag, "/exp_digest"}, exp_digest_o, packed_exp());
    chk({tag, "/digest"}, digest_o, m_dig);
`endif
    chk({tag, "/done"}, W'(capture_done_o), W'(done));
    chk({tag, "/alert"}, W'(alert_o), W'(m_alert));
    chk({tag, "/pulses"}, W'(pulses), W'(exp_start >= 0 ? 1 : 0));
    chk({tag, "/start_cycle"}, W'(act_start), W'(exp_start));
  endtask

  initial begin
    do_reset("t0");
    sweep(0, RomDepth - 1, -1);
    cyc(0, 0, 1);
    repeat (2) cyc(0, 0, 0);
    check_all("t1_full_sweep");
    cyc(0, 0, 1);
    cyc(0, 0, 0);
    check_all("t5_second_kmac");
    do_reset("t2");
    sweep(0, RomDepth - 1, 100);
    repeat (2) cyc(0, 0, 0);
    check_all("t2_early_kmac");
    do_reset("t3");
    sweep(8000, RomDepth - 1, RomDepth - 1);
    repeat (2) cyc(0, 0, 0);
    check_all("t3_same_cycle");
    do_reset("t7");
    sweep(8150, RomDepth - 1, int'($urandom_range(TopBase - 4, RomDepth - 1)));
    repeat (2) cyc(0, 0, 0);
    check_all("t7_random_kmac");
    do_reset("t4");
    cyc(1, 8184, 0);
    cyc(1, 8186, 0);
    chk("t4_alert_at_8186", W'(alert_o), W'(1));
    for (int a = 8187; a < RomDepth; a++) cyc(1, a, 0);
    cyc(0, 0, 1);
    repeat (2) cyc(0, 0, 0);
    check_all("t4_out_of_order");
    do_reset("t6");
    sweep(8100, 8188, -1);
    check_all("t6_partial");
    do_reset("t6_mid");
    sweep(0, RomDepth - 1, int'($urandom_range(0, TopBase - 1)));
    repeat (2) cyc(0, 0, 0);
    check_all("t6_resweep");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
